// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a fixed clocks-per-bit ratio and framing-error detection.
// Ports: i_Clock/i_Reset (sync, active-high), i_RX_Serial (async line, idles high),
//        o_RX_DV (1-cycle byte strobe), o_RX_Byte (last good byte), o_RX_Active (frame in progress),
//        o_RX_Frame_Err (1-cycle strobe when the stop bit is sampled low).
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);
  localparam logic [15:0] H = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, byte_n;
  logic dv_n, active_n, ferr_n;
  logic rx_s;
  assign rx_s = sync[1];
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      sync           <= 2'b11;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      o_RX_Byte      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      state          <= state_n;
      sync           <= {sync[0], i_RX_Serial};
      cnt            <= cnt_n;
      idx            <= idx_n;
      shift          <= shift_n;
      o_RX_Byte      <= byte_n;
      o_RX_DV        <= dv_n;
      o_RX_Active    <= active_n;
      o_RX_Frame_Err <= ferr_n;
    end
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    byte_n   = o_RX_Byte;
    dv_n     = 1'b0;
    ferr_n   = 1'b0;
    active_n = o_RX_Active;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: begin
        cnt_n = cnt + 16'd1;
        if (cnt == H) begin
          // line still low at mid start bit: real start; otherwise a glitch
          cnt_n    = '0;
          state_n  = rx_s ? IDLE : DATA;
          active_n = !rx_s;
        end
      end
      DATA: begin
        cnt_n = cnt + 16'd1;
        if (cnt == LAST) begin
          cnt_n          = '0;
          shift_n[idx]   = rx_s;
          idx_n          = idx + 3'd1;
          state_n        = (idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        cnt_n = cnt + 16'd1;
        if (cnt == LAST) begin
          cnt_n    = '0;
          active_n = 1'b0;
          byte_n   = rx_s ? shift : o_RX_Byte;
          dv_n     = rx_s;
          ferr_n   = !rx_s;
          state_n  = rx_s ? CLEANUP : WAIT_HIGH;
        end
      end
      CLEANUP: state_n = IDLE;
      // a held-low (break) line must not be mistaken for a new start bit
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx using a serial frame driver and an expected-byte queue.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int CPB2 = 217;
  localparam int H1 = (CPB - 1) / 2;
  localparam int H2 = (CPB2 - 1) / 2;
  logic clk = 0, rst = 1, rx16 = 1, rx217 = 1;
  logic dv16, act16, fe16, dv217, act217, fe217;
  logic [7:0] byte16, byte217;
  always #5 clk = ~clk;
  uart_rx #(.CLKS_PER_BIT(CPB)) dut16 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx16),
    .o_RX_DV(dv16), .o_RX_Byte(byte16), .o_RX_Active(act16), .o_RX_Frame_Err(fe16)
  );
  uart_rx #(.CLKS_PER_BIT(CPB2)) dut217 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx217),
    .o_RX_DV(dv217), .o_RX_Byte(byte217), .o_RX_Active(act217), .o_RX_Frame_Err(fe217)
  );
  int ntests = 0, nfail = 0, viol = 0;
  int fe16_n = 0, fe217_n = 0, act16_n = 0;
  longint cyc = 0, fall16 = 0, fall217 = 0;
  logic rst_edge = 1'b1;
  logic [7:0] prev16 = 8'h00;
  logic [7:0] q16[$], q217[$], expq[$];
  longint c16[$], c217[$];
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end
  always @(negedge clk) begin
    if (dv16) begin q16.push_back(byte16); c16.push_back(cyc); end
    if (dv217) begin q217.push_back(byte217); c217.push_back(cyc); end
    if (fe16) fe16_n++;
    if (fe217) fe217_n++;
    if (act16) act16_n++;
    if ((dv16 && fe16) || (dv217 && fe217)) viol++;
    if (!dv16 && !rst_edge && byte16 !== prev16) viol++;
    prev16 = byte16;
  end
  task automatic check(input string name, input longint act, input longint exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input bit which, input logic [7:0] b, input logic stop_v);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (which) rx217 = f[i]; else rx16 = f[i];
      if (i == 0) begin if (which) fall217 = cyc; else fall16 = cyc; end
      repeat (which ? CPB2 : CPB) @(negedge clk);
    end
  endtask
  task automatic idle16(input int n);
    rx16 = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t tbl[9];
  initial begin
    int f0;
    tbl[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
    tbl[1] = '{8'h55, 1'b1, 1, 0, 8'h55};
    tbl[2] = '{8'hAA, 1'b1, 1, 0, 8'hAA};
    tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    tbl[4] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    tbl[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
    tbl[6] = '{8'h7E, 1'b0, 0, 1, 8'h81};
    tbl[7] = '{8'h00, 1'b0, 0, 1, 8'h81};
    tbl[8] = '{8'h01, 1'b1, 1, 0, 8'h01};
    repeat (4) @(negedge clk);
    check("reset dv", dv16, 0);
    check("reset byte", byte16, 0);
    check("reset active", act16, 0);
    check("reset ferr", fe16, 0);
    rst = 1'b0;
    idle16(4);
    // ideal 0x37 frame at CPB=16: latency and active window
    act16_n = 0;
    send(0, 8'h37, 1'b1);
    idle16(2 * CPB);
    check("f37 dv count", q16.size(), 1);
    check("f37 byte", q16[0], 8'h37);
    check("f37 dv cycle", c16[0] - fall16, 4 + H1 + 9 * CPB);
    check("f37 active cycles", act16_n, 9 * CPB);
    // same frame at the default ratio
    send(1, 8'h37, 1'b1);
    repeat (CPB2) @(negedge clk);
    check("f37@217 dv count", q217.size(), 1);
    check("f37@217 byte", q217[0], 8'h37);
    check("f37@217 dv cycle", c217[0] - fall217, 4 + H2 + 9 * CPB2);
    check("f37@217 ferr", fe217_n, 0);
    // back-to-back frames with no idle gap
    q16.delete(); c16.delete();
    send(0, 8'hA5, 1'b1);
    send(0, 8'h00, 1'b1);
    idle16(2 * CPB);
    check("b2b count", q16.size(), 2);
    check("b2b first", q16[0], 8'hA5);
    check("b2b second", q16[1], 8'h00);
    check("b2b spacing", c16[1] - c16[0], 10 * CPB);
    // short low glitch must be rejected
    q16.delete(); c16.delete();
    f0 = fe16_n;
    rx16 = 1'b0;
    repeat (5) @(negedge clk);
    idle16(3 * CPB);
    check("glitch dv", q16.size(), 0);
    check("glitch ferr", fe16_n - f0, 0);
    check("glitch active", act16, 0);
    send(0, 8'h5A, 1'b1);
    idle16(2 * CPB);
    check("post-glitch count", q16.size(), 1);
    check("post-glitch byte", q16[0], 8'h5A);
    // stop bit low then break held low for 40 cycles
    q16.delete(); c16.delete();
    f0 = fe16_n;
    send(0, 8'hFF, 1'b0);
    repeat (40) @(negedge clk);
    check("break no dv", q16.size(), 0);
    check("break ferr", fe16_n - f0, 1);
    check("break byte kept", byte16, 8'h5A);
    idle16(12 * CPB);
    check("break no restart dv", q16.size(), 0);
    check("break ferr once", fe16_n - f0, 1);
    send(0, 8'h81, 1'b1);
    idle16(2 * CPB);
    check("post-break count", q16.size(), 1);
    check("post-break byte", q16[0], 8'h81);
    // reset in the middle of data bit 3 of 0xC3
    q16.delete(); c16.delete();
    f0 = fe16_n;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] fr;
      fr = {1'b1, 8'hC3, 1'b0};
      rx16 = fr[i];
      repeat (i == 3 ? CPB / 2 : CPB) @(negedge clk);
    end
    check("pre-reset active", act16, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset dv", dv16, 0);
    check("mid reset byte", byte16, 0);
    check("mid reset active", act16, 0);
    check("mid reset ferr", fe16, 0);
    rst = 1'b0;
    idle16(12 * CPB);
    check("aborted no dv", q16.size(), 0);
    check("aborted no ferr", fe16_n - f0, 0);
    send(0, 8'h3C, 1'b1);
    idle16(2 * CPB);
    check("post-reset count", q16.size(), 1);
    check("post-reset byte", q16[0], 8'h3C);
    // table of frames with good and bad stop bits
    foreach (tbl[k]) begin
      q16.delete(); c16.delete();
      f0 = fe16_n;
      send(0, tbl[k].data, tbl[k].stop);
      idle16(2 * CPB);
      check($sformatf("tbl%0d dv", k), q16.size(), tbl[k].exp_dv);
      check($sformatf("tbl%0d ferr", k), fe16_n - f0, tbl[k].exp_fe);
      check($sformatf("tbl%0d byte", k), byte16, tbl[k].exp_byte);
    end
    // loopback stream: fixed bytes then random ones with random idle gaps
    q16.delete(); c16.delete();
    f0 = fe16_n;
    for (int i = 0; i < 260; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'h55 : (i == 2) ? 8'hAA : (i == 3) ? 8'hFF : 8'($urandom);
      expq.push_back(b);
      send(0, b, 1'b1);
      idle16($urandom_range(0, 3) * (CPB / 2));
    end
    idle16(2 * CPB);
    check("loop count", q16.size(), expq.size());
    check("loop ferr", fe16_n - f0, 0);
    foreach (expq[i]) check($sformatf("loop byte %0d", i), q16[i], expq[i]);
    check("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the counterpart to the team's UART_TX.
- Recovers 8N1 serial frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from an asynchronous line.
- Uses a fixed integer clocks-per-bit ratio.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Sits at the chip pin boundary, feeding command/data logic.

Parameters:
- CLKS_PER_BIT, 217, i_Clock cycles per serial bit (e.g. 25 MHz / 115200). Legal range 4..65535. Internal bit counter is 16 bits wide.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  synchronous reset, active-high
- i_RX_Serial  input  1  asynchronous serial line, idles high
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte holds a newly received valid byte
- o_RX_Byte  output  8  last correctly framed byte, LSB = first data bit received
- o_RX_Active  output  1  high while a frame is being received (START through STOP)
- o_RX_Frame_Err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Clock and reset: one clock (i_Clock). Reset is synchronous and active-high (i_Reset), sampled on the rising edge of i_Clock.
- Reset values:
  - state = IDLE; bit counter = 0; bit index = 0; shift register = 0.
  - Both synchronizer flops = 1.
  - o_RX_DV = 0, o_RX_Byte = 0x00, o_RX_Active = 0, o_RX_Frame_Err = 0.
- Reset mid-frame aborts the frame. No DV or Frame_Err is produced for the aborted frame.
- Input sync:
  - i_RX_Serial passes through a 2-flop synchronizer. All decisions use the 2nd flop output (rx_s).
  - Sync latency is 2 cycles.
- Timing constant: H = (CLKS_PER_BIT-1)/2, using integer division.
- States:
  - IDLE:
    - Counter and index are held at 0.
    - If rx_s == 0, go to START with counter = 0.
  - START:
    - Counter increments each cycle.
    - When counter == H, sample rx_s:
      - rx_s == 0: counter <= 0, go to DATA, o_RX_Active <= 1.
      - rx_s == 1: glitch; return to IDLE and produce no output.
  - DATA:
    - Counter increments until it reaches CLKS_PER_BIT-1. At that cycle, sample rx_s into shift[index] and set counter <= 0.
    - If index < 7: index++.
    - If index == 7: index <= 0, go to STOP.
  - STOP:
    - Counter increments until it reaches CLKS_PER_BIT-1. At that cycle, sample rx_s and set o_RX_Active <= 0.
    - rx_s == 1: o_RX_Byte <= shift; o_RX_DV <= 1 for exactly 1 cycle; go to CLEANUP.
    - rx_s == 0: o_RX_Frame_Err <= 1 for exactly 1 cycle; o_RX_Byte is unchanged; go to WAIT_HIGH.
  - CLEANUP: one cycle; DV is deasserted; go to IDLE.
  - WAIT_HIGH:
    - Remain until rx_s == 1, then go to IDLE.
    - Prevents a break condition (line held low) from retriggering a start.
  - Any undefined encoding goes to IDLE.
- Latency:
  - T is the cycle IDLE sees rx_s == 0.
  - Start sample at T+1+H.
  - Bit k sampled at T+1+H+(k+1)·CLKS_PER_BIT.
  - Stop sampled at T+1+H+9·CLKS_PER_BIT.
  - o_RX_DV high in cycle T+2+H+9·CLKS_PER_BIT.
- Back-to-back frames:
  - A new start bit immediately following the stop bit must be accepted.
  - The IDLE→START transition occurs within 2 cycles of the stop-bit sample. Worst-case drift budget is ±H cycles per frame.
- o_RX_DV and o_RX_Frame_Err are never high in the same cycle.
- o_RX_Byte is stable except in the DV cycle.

Test Plan:
- Run with CLKS_PER_BIT=16 for all scenarios; additionally repeat the first at the default 217.
- Drive an ideal 8N1 frame of 0x37 → o_RX_DV high for exactly 1 cycle with o_RX_Byte=0x37. DV cycle matches the latency formula (T+2+7+144). o_RX_Active is high from start sample to stop sample.
- Back-to-back 0xA5 then 0x00, no idle gap → two DV strobes, bytes 0xA5 then 0x00, spaced 10·16=160 cycles apart.
- Low glitch of 5 cycles (< H=7) on an idle line → no DV, no Frame_Err; state returns to IDLE; a subsequent 0x5A frame is received correctly.
- Frame 0xFF with the stop bit driven low, line then held low 40 cycles → Frame_Err 1 cycle, no DV, o_RX_Byte keeps its previous value. No new frame starts until the line goes high; a following 0x81 frame gives DV with 0x81.
- Assert i_Reset for 1 cycle during data bit 3 of frame 0xC3 → all outputs go to 0 on the next edge and no DV occurs. A following clean 0x3C frame is received correctly.
- Loopback from UART_TX (same CLKS_PER_BIT=16), bytes 0x00, 0x55, 0xAA, 0xFF, then 256 random bytes → every byte matches and no Frame_Err.
